mult_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one shift-add multiplier (start/done four-phase

---
 rtl/mult_rr_arbiter_if.sv | 30 +++
 rtl/mult_rr_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mult_rr_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_rr_arbiter_if.sv
// Requester, result and multiplier-side signal bundle for mult_rr_arbiter.
// master = arbiter side, slave = requesters plus multiplier.
interface mult_rr_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [2*WIDTH-1:0]    p_out;
   logic                  busy;
   logic                  err;
   logic                  m_start;
   logic [WIDTH-1:0]      m_a;
   logic [WIDTH-1:0]      m_b;
   logic                  m_done;
   logic [2*WIDTH-1:0]    m_p;

   modport master (
      input  req, a_in, b_in, m_done, m_p,
      output gnt, ack, p_out, busy, err, m_start, m_a, m_b
   );

   modport slave (
      output req, a_in, b_in, m_done, m_p,
      input  gnt, ack, p_out, busy, err, m_start, m_a, m_b
   );
endinterface

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one start/done shift-add multiplier among NREQ requesters.
// Optional BUSY watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_rr_arbiter #(
   parameter int WIDTH          = 8,
   parameter int NREQ           = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   mult_rr_arbiter_if.master bus
);
   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PW-1:0]       r_ptr;
   logic [NREQ-1:0]     r_gnt;
   logic [NREQ-1:0]     r_ack;
   logic [2*WIDTH-1:0]  r_p;
   logic                r_start;
   logic [WIDTH-1:0]    r_ma;
   logic [WIDTH-1:0]    r_mb;
   logic                r_busy;
   logic                r_err;

   logic [PW-1:0]       w_win;
   logic                w_any;
   logic                w_tmo_hit;
   logic [PW-1:0]       w_ptr_nxt;
   logic [NREQ-1:0]     w_gnt_nxt;
   logic [NREQ-1:0]     w_ack_nxt;
   logic [2*WIDTH-1:0]  w_p_nxt;
   logic                w_start_nxt;
   logic [WIDTH-1:0]    w_ma_nxt;
   logic [WIDTH-1:0]    w_mb_nxt;
   logic                w_busy_nxt;
   logic                w_err_nxt;

   // Winner search: scan downward so the requester closest to ptr is written last.
   always_comb begin
      int w_idx;
      w_win = '0;
      w_any = 1'b0;
      w_idx = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NREQ) begin
            w_idx = w_idx - NREQ;
         end else begin
            w_idx = w_idx;
         end
         if (bus.req[w_idx]) begin
            w_win = w_idx[PW-1:0];
            w_any = 1'b1;
         end else begin
            w_win = w_win;
            w_any = w_any;
         end
      end
   end

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tmo;

   assign w_tmo_hit = (r_state == S_BUSY) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

   // Watchdog counter: held at zero outside BUSY, so it is clear on every BUSY entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo <= '0;
      end else if (r_state != S_BUSY) begin
         r_tmo <= '0;
      end else begin
         r_tmo <= r_tmo + TW'(1);
      end
   end
`else
   assign w_tmo_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; done takes priority over a coincident timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any) w_state_nxt = S_BUSY;
            else       w_state_nxt = S_IDLE;
         end
         S_BUSY: begin
            if (bus.m_done)     w_state_nxt = S_RELEASE;
            else if (w_tmo_hit) w_state_nxt = S_RELEASE;
            else                w_state_nxt = S_BUSY;
         end
         S_RELEASE: begin
            if (!bus.m_done) w_state_nxt = S_IDLE;
            else             w_state_nxt = S_RELEASE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; ack and err default to a single-cycle pulse.
   always_comb begin
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = r_gnt;
      w_ack_nxt   = '0;
      w_p_nxt     = r_p;
      w_start_nxt = r_start;
      w_ma_nxt    = r_ma;
      w_mb_nxt    = r_mb;
      w_busy_nxt  = r_busy;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_gnt_nxt   = NREQ'(1) << w_win;
               w_ma_nxt    = bus.a_in[int'(w_win)*WIDTH +: WIDTH];
               w_mb_nxt    = bus.b_in[int'(w_win)*WIDTH +: WIDTH];
               w_start_nxt = 1'b1;
               w_busy_nxt  = 1'b1;
               w_ptr_nxt   = (w_win == PW'(NREQ - 1)) ? PW'(0) : (w_win + PW'(1));
            end else begin
               w_start_nxt = 1'b0;
            end
         end
         S_BUSY: begin
            if (bus.m_done) begin
               w_p_nxt     = bus.m_p;
               w_ack_nxt   = r_gnt;
               w_start_nxt = 1'b0;
            end else if (w_tmo_hit) begin
               w_err_nxt   = 1'b1;
               w_start_nxt = 1'b0;
            end else begin
               w_start_nxt = 1'b1;
            end
         end
         S_RELEASE: begin
            if (!bus.m_done) begin
               w_gnt_nxt  = '0;
               w_busy_nxt = 1'b0;
            end else begin
               w_gnt_nxt  = r_gnt;
            end
         end
         default: begin
            w_gnt_nxt   = '0;
            w_start_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // Output and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_p     <= '0;
         r_start <= 1'b0;
         r_ma    <= '0;
         r_mb    <= '0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ack   <= w_ack_nxt;
         r_p     <= w_p_nxt;
         r_start <= w_start_nxt;
         r_ma    <= w_ma_nxt;
         r_mb    <= w_mb_nxt;
         r_busy  <= w_busy_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.ack     = r_ack;
   assign bus.p_out   = r_p;
   assign bus.m_start = r_start;
   assign bus.m_a     = r_ma;
   assign bus.m_b     = r_mb;
   assign bus.busy    = r_busy;
   assign bus.err     = r_err;
endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Randomized bench for mult_rr_arbiter with a behavioural multiplier and round-robin reference model.
// Timeout scenario is included when MULT_ARB_TIMEOUT_EN is defined.
module tb_mult_rr_arbiter;
   localparam int W  = 8;
   localparam int N  = 4;
   localparam int PW2 = 2 * W;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mult_rr_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
   mult_rr_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int             exp_ptr;
   logic [PW2-1:0] last_p;
   logic [W-1:0]   op_a [N];
   logic [W-1:0]   op_b [N];

   // behavioural multiplier
   bit mult_stuck = 1'b0;
   int mult_cnt   = 0;
   int mult_delay = 0;

   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         bus.m_done = 1'b0;
         mult_cnt   = 0;
      end else if (!bus.m_done) begin
         if (bus.m_start && !mult_stuck) begin
            if (mult_cnt >= mult_delay) begin
               bus.m_p    = PW2'(int'(bus.m_a) * int'(bus.m_b));
               bus.m_done = 1'b1;
               mult_cnt   = 0;
               mult_delay = $urandom_range(0, 4);
            end else begin
               mult_cnt++;
            end
         end else begin
            mult_cnt = 0;
         end
      end else if (!bus.m_start) begin
         bus.m_done = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [PW2-1:0] prod(input int i);
      return PW2'(int'(op_a[i]) * int'(op_b[i]));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_ops();
      for (int i = 0; i < N; i++) begin
         bus.a_in[i*W +: W] = op_a[i];
         bus.b_in[i*W +: W] = op_b[i];
      end
   endtask

   task automatic settle();
      int n;
      n = 0;
      while (n < 20 && bus.busy) begin
         tick();
         n++;
      end
   endtask

   // Waits for the grant, optionally disturbs the winner, then waits for the ack.
   task automatic serve(input int w, input bit scramble, input bit dropr,
                        output int lat, output logic [N-1:0] g,
                        output logic [W-1:0] ma, output logic [W-1:0] mb,
                        output logic [N-1:0] ackv, output logic [PW2-1:0] p);
      int n;
      lat = 0;
      while (lat < 20 && !bus.m_start) begin
         tick();
         lat++;
      end
      g  = bus.gnt;
      ma = bus.m_a;
      mb = bus.m_b;
      if (w >= 0 && scramble) begin
         bus.a_in[w*W +: W] = W'($urandom);
         bus.b_in[w*W +: W] = W'($urandom);
      end
      if (w >= 0 && dropr) bus.req[w] = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (n < 20 && bus.ack == '0);
      ackv = bus.ack;
      p    = bus.p_out;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      bus.req    = '0;
      bus.a_in   = '0;
      bus.b_in   = '0;
      bus.m_done = 1'b0;
      bus.m_p    = '0;
      repeat (3) tick();
      n_checks++;
      if ({bus.gnt, bus.ack, bus.p_out, bus.m_start, bus.m_a, bus.m_b, bus.busy, bus.err} !== '0)
         $display("FAIL reset_outputs: got gnt=%b ack=%b p=%0d start=%b busy=%b err=%b",
                  bus.gnt, bus.ack, bus.p_out, bus.m_start, bus.busy, bus.err);
      else n_pass++;
      rst     = 1'b0;
      exp_ptr = 0;
      last_p  = '0;
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.m_start !== 1'b0)
         $display("FAIL idle_no_req: got busy=%b start=%b expected 0 0", bus.busy, bus.m_start);
      else n_pass++;
   endtask

   task automatic test_pair();
      int lat, w;
      logic [N-1:0] g, ackv;
      logic [W-1:0] ma, mb;
      logic [PW2-1:0] p;
      op_a[0] = 8'd3; op_b[0] = 8'd4;
      op_a[2] = 8'd9; op_b[2] = 8'd11;
      apply_ops();
      bus.req = 4'b0101;
      for (int t = 0; t < 2; t++) begin
         w = rr_pick(bus.req, exp_ptr);
         exp_ptr = (w + 1) % N;
         serve(w, 1'b0, 1'b0, lat, g, ma, mb, ackv, p);
         n_checks++;
         if (ackv !== N'(1 << w) || g !== N'(1 << w))
            $display("FAIL pair_order%0d: got gnt=%b ack=%b expected %b", t, g, ackv, N'(1 << w));
         else n_pass++;
         n_checks++;
         if (p !== prod(w)) $display("FAIL pair_product%0d: got %0d expected %0d", t, p, prod(w));
         else n_pass++;
         last_p = prod(w);
         bus.req[w] = 1'b0;
      end
   endtask

   task automatic test_basic();
      int lat, w;
      logic [N-1:0] g, ackv;
      logic [W-1:0] ma, mb;
      logic [PW2-1:0] p;
      settle();
      op_a[0] = 8'd5; op_b[0] = 8'd7;
      apply_ops();
      bus.req = 4'b0001;
      w = rr_pick(bus.req, exp_ptr);
      exp_ptr = (w + 1) % N;
      serve(w, 1'b0, 1'b0, lat, g, ma, mb, ackv, p);
      n_checks++;
      if (lat !== 1) $display("FAIL basic_start_latency: got %0d cycles expected 1", lat);
      else n_pass++;
      n_checks++;
      if (ma !== 8'd5 || mb !== 8'd7) $display("FAIL basic_operands: got %0d,%0d expected 5,7", ma, mb);
      else n_pass++;
      n_checks++;
      if (ackv !== 4'b0001 || p !== 16'd35)
         $display("FAIL basic_result: got ack=%b p=%0d expected 0001 35", ackv, p);
      else n_pass++;
      last_p = 16'd35;
      bus.req = '0;
      repeat (3) tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.p_out !== last_p)
         $display("FAIL basic_idle_hold: got busy=%b gnt=%b p=%0d expected 0 0000 %0d",
                  bus.busy, bus.gnt, bus.p_out, last_p);
      else n_pass++;
   endtask

   task automatic test_corner();
      int lat, w;
      logic [N-1:0] g, ackv;
      logic [W-1:0] ma, mb;
      logic [PW2-1:0] p;
      logic [PW2-1:0] want [2];
      int who [2];
      want[0] = 16'd65025; want[1] = 16'd0;
      who[0]  = 3;         who[1]  = 1;
      op_a[3] = 8'd255; op_b[3] = 8'd255;
      op_a[1] = 8'd0;   op_b[1] = 8'd200;
      apply_ops();
      for (int t = 0; t < 2; t++) begin
         settle();
         bus.req = N'(1 << who[t]);
         w = rr_pick(bus.req, exp_ptr);
         exp_ptr = (w + 1) % N;
         serve(w, 1'b0, 1'b0, lat, g, ma, mb, ackv, p);
         n_checks++;
         if (p !== want[t] || ackv !== N'(1 << who[t]))
            $display("FAIL corner%0d: got p=%0d ack=%b expected %0d %b", t, p, ackv, want[t], N'(1 << who[t]));
         else n_pass++;
         last_p = want[t];
         bus.req = '0;
      end
   endtask

   task automatic test_held_all();
      int lat, w;
      int cnt [N];
      logic [N-1:0] g, ackv;
      logic [W-1:0] ma, mb;
      logic [PW2-1:0] p;
      bit starved;
      settle();
      for (int i = 0; i < N; i++) begin
         op_a[i] = W'($urandom); op_b[i] = W'($urandom); cnt[i] = 0;
      end
      apply_ops();
      bus.req = 4'b1111;
      for (int t = 0; t < 2 * N; t++) begin
         w = rr_pick(4'b1111, exp_ptr);
         exp_ptr = (w + 1) % N;
         serve(w, 1'b0, 1'b0, lat, g, ma, mb, ackv, p);
         n_checks++;
         if (g !== N'(1 << w) || ackv !== N'(1 << w) || p !== prod(w))
            $display("FAIL held_txn%0d: got gnt=%b ack=%b p=%0d expected %b %0d", t, g, ackv, p, N'(1 << w), prod(w));
         else n_pass++;
         for (int i = 0; i < N; i++) if (ackv[i]) cnt[i]++;
         last_p = prod(w);
         op_a[w] = W'($urandom); op_b[w] = W'($urandom);
         apply_ops();
      end
      starved = 1'b0;
      for (int i = 0; i < N; i++) if (cnt[i] != 2) starved = 1'b1;
      n_checks++;
      if (starved) $display("FAIL held_fairness: got counts %0d %0d %0d %0d expected 2 each",
                            cnt[0], cnt[1], cnt[2], cnt[3]);
      else n_pass++;
      bus.req = '0;
   endtask

   task automatic test_random();
      int lat, w;
      logic [N-1:0] g, ackv, pend, add;
      logic [W-1:0] ma, mb;
      logic [PW2-1:0] p;
      bit scr, drp;
      settle();
      pend = '0;
      for (int t = 0; t < 40; t++) begin
         if (pend == '0 || $urandom_range(0, 1) == 1) begin
            add = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
               if (add[i] && !pend[i]) begin
                  op_a[i] = W'($urandom); op_b[i] = W'($urandom);
                  bus.a_in[i*W +: W] = op_a[i];
                  bus.b_in[i*W +: W] = op_b[i];
               end
            end
            pend = pend | add;
         end
         bus.req = pend;
         w = rr_pick(pend, exp_ptr);
         exp_ptr = (w + 1) % N;
         scr = ($urandom_range(0, 3) == 0);
         drp = ($urandom_range(0, 3) == 0);
         serve(w, scr, drp, lat, g, ma, mb, ackv, p);
         n_checks++;
         if (g !== N'(1 << w) || ma !== op_a[w] || mb !== op_b[w])
            $display("FAIL rand_grant%0d: got gnt=%b a=%0d b=%0d expected %b %0d %0d",
                     t, g, ma, mb, N'(1 << w), op_a[w], op_b[w]);
         else n_pass++;
         n_checks++;
         if (ackv !== N'(1 << w) || p !== prod(w) || bus.err !== 1'b0)
            $display("FAIL rand_result%0d: got ack=%b p=%0d err=%b expected %b %0d 0",
                     t, ackv, p, bus.err, N'(1 << w), prod(w));
         else n_pass++;
         last_p = prod(w);
         pend[w] = 1'b0;
         bus.req = pend;
      end
      bus.req = '0;
   endtask

   task automatic test_reset_mid_busy();
      int lat, w;
      logic [N-1:0] g, ackv;
      logic [W-1:0] ma, mb;
      logic [PW2-1:0] p;
      settle();
      mult_stuck = 1'b1;
      op_a[0] = 8'd12; op_b[0] = 8'd13;
      apply_ops();
      bus.req = 4'b0001;
      repeat (4) tick();
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.gnt, bus.ack, bus.p_out, bus.m_start, bus.m_a, bus.m_b, bus.busy, bus.err} !== '0)
         $display("FAIL async_reset: got gnt=%b start=%b busy=%b p=%0d expected all 0",
                  bus.gnt, bus.m_start, bus.busy, bus.p_out);
      else n_pass++;
      tick();
      mult_stuck = 1'b0;
      exp_ptr = 0;
      last_p = '0;
      op_a[1] = 8'd6; op_b[1] = 8'd9;
      apply_ops();
      bus.req = 4'b0010;
      rst = 1'b0;
      w = rr_pick(bus.req, exp_ptr);
      exp_ptr = (w + 1) % N;
      serve(w, 1'b0, 1'b0, lat, g, ma, mb, ackv, p);
      n_checks++;
      if (lat !== 1 || ackv !== 4'b0010 || p !== 16'd54)
         $display("FAIL after_reset: got lat=%0d ack=%b p=%0d expected 1 0010 54", lat, ackv, p);
      else n_pass++;
      last_p = 16'd54;
      bus.req = '0;
   endtask

`ifdef MULT_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int lat, w, n;
      logic [N-1:0] g, ackv;
      logic [W-1:0] ma, mb;
      logic [PW2-1:0] p;
      settle();
      mult_stuck = 1'b1;
      op_a[2] = 8'd21; op_b[2] = 8'd3;
      apply_ops();
      bus.req = 4'b0100;
      w = rr_pick(bus.req, exp_ptr);
      exp_ptr = (w + 1) % N;
      lat = 0;
      while (lat < 20 && !bus.m_start) begin
         tick();
         lat++;
      end
      n = 0;
      while (n < 200 && !bus.err) begin
         tick();
         n++;
      end
      n_checks++;
      if (n !== TMO || bus.err !== 1'b1) $display("FAIL timeout_cycles: got %0d expected %0d", n, TMO);
      else n_pass++;
      n_checks++;
      if (bus.ack !== '0 || bus.m_start !== 1'b0 || bus.p_out !== last_p)
         $display("FAIL timeout_state: got ack=%b start=%b p=%0d expected 0000 0 %0d",
                  bus.ack, bus.m_start, bus.p_out, last_p);
      else n_pass++;
      bus.req = '0;
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.err !== 1'b0)
         $display("FAIL timeout_idle: got busy=%b gnt=%b err=%b expected 0 0000 0", bus.busy, bus.gnt, bus.err);
      else n_pass++;
      mult_stuck = 1'b0;
      op_a[0] = 8'd2; op_b[0] = 8'd2; op_a[3] = 8'd4; op_b[3] = 8'd4;
      apply_ops();
      bus.req = 4'b1001;
      w = rr_pick(bus.req, exp_ptr);
      exp_ptr = (w + 1) % N;
      serve(w, 1'b0, 1'b0, lat, g, ma, mb, ackv, p);
      n_checks++;
      if (g !== N'(1 << w) || p !== prod(w))
         $display("FAIL timeout_ptr: got gnt=%b p=%0d expected %b %0d", g, p, N'(1 << w), prod(w));
      else n_pass++;
      bus.req = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_pair();
      test_basic();
      test_corner();
      test_held_all();
      test_random();
      test_reset_mid_busy();
`ifdef MULT_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
